// File: rtl/splash_compositor.sv
// splash_compositor: layered SRAM image compositor with frame-stepped brightness fades
module splash_compositor #(
    parameter int                         NUM_LAYERS = 3,
    parameter int                         X_START    = 216,
    parameter int                         Y_START    = 27,
    parameter logic [12*NUM_LAYERS-1:0]   LAYER_X    = {12'd0, 12'd695, 12'd300},
    parameter logic [12*NUM_LAYERS-1:0]   LAYER_Y    = {12'd0, 12'd0, 12'd200},
    parameter logic [12*NUM_LAYERS-1:0]   LAYER_W    = {12'd100, 12'd100, 12'd200},
    parameter logic [12*NUM_LAYERS-1:0]   LAYER_H    = {12'd600, 12'd100, 12'd200},
    parameter logic [20*NUM_LAYERS-1:0]   LAYER_BASE = {20'hB98C0, 20'hC8320, 20'h00000},
    parameter logic [23:0]                BG_RGB     = 24'hF8F8F8,
    parameter int                         FADE_DIV   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic signed [12:0] i_h_count,
    input  logic signed [12:0] i_v_count,
    output logic [19:0]        o_sram_addr,
    output logic               o_sram_req,
    input  logic [15:0]        i_sram_data,
    input  logic               i_key,
    input  logic               i_restart,
    output logic [9:0]         o_red,
    output logic [9:0]         o_green,
    output logic [9:0]         o_blue,
    output logic               o_opening,
    output logic [4:0]         o_fade_level
);
    typedef enum logic [1:0] {FADE_IN, OPENING, FADE_OUT, DONE} state_e;

    localparam logic [15:0] DIV_LAST = 16'(FADE_DIV - 1);

    state_e                 state_q;
    logic [4:0]             level_q;
    logic [15:0]            div_q;
    logic                   opening_q;
    logic [NUM_LAYERS-1:0]  win;
    logic [19:0]            cnt_q [NUM_LAYERS];
    logic                   refresh;
    logic                   opaque;
    logic [9:0]             red_d, green_d, blue_d;
    logic [9:0]             red_q, green_q, blue_q;

    assign refresh      = (i_h_count == 13'sd0) && (i_v_count == 13'sd0);
    assign o_fade_level = level_q;
    assign o_opening    = opening_q;
    assign o_red        = red_q;
    assign o_green      = green_q;
    assign o_blue       = blue_q;

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        localparam logic signed [12:0] XL = 13'(X_START + int'(LAYER_X[12*k +: 12]));
        localparam logic signed [12:0] XR = 13'(X_START + int'(LAYER_X[12*k +: 12]) + int'(LAYER_W[12*k +: 12]));
        localparam logic signed [12:0] YT = 13'(Y_START + int'(LAYER_Y[12*k +: 12]));
        localparam logic signed [12:0] YB = 13'(Y_START + int'(LAYER_Y[12*k +: 12]) + int'(LAYER_H[12*k +: 12]));
        assign win[k] = (i_h_count >= XL) && (i_h_count < XR) && (i_v_count >= YT) && (i_v_count < YB);
        // Every hit advances its counter, even when occluded, so each image stays aligned
        always_ff @(posedge i_clk) begin
            if (i_rst || refresh) begin
                cnt_q[k] <= LAYER_BASE[20*k +: 20];
            end else if (win[k]) begin
                cnt_q[k] <= cnt_q[k] + 20'd1;
            end
        end
    end

    // Lowest-index hit layer owns the single SRAM read this cycle
    always_comb begin
        o_sram_addr = '0;
        o_sram_req  = 1'b0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (win[k]) begin
                o_sram_addr = cnt_q[k];
                o_sram_req  = 1'b1;
            end
        end
    end

    function automatic logic [9:0] scale(input logic [9:0] c, input logic [4:0] l);
        return 10'((15'(c) * 15'(l)) >> 4);
    endfunction

    // Transparent winner pixels show the background; there is no fall-through
    always_comb begin
        opaque  = o_sram_req && i_sram_data[0];
        red_d   = opaque ? {i_sram_data[15:11], i_sram_data[15:11]} : {BG_RGB[23:16], 2'b00};
        green_d = opaque ? {i_sram_data[10:6], i_sram_data[10:6]}   : {BG_RGB[15:8], 2'b00};
        blue_d  = opaque ? {i_sram_data[5:1], i_sram_data[5:1]}     : {BG_RGB[7:0], 2'b00};
    end

    // Register the faded pixel colour for one cycle of latency
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            red_q   <= scale(red_d, level_q);
            green_q <= scale(green_d, level_q);
            blue_q  <= scale(blue_d, level_q);
        end
    end

    // Fade sequencer: brightness steps once every FADE_DIV frames
    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            state_q   <= FADE_IN;
            level_q   <= '0;
            div_q     <= '0;
            opening_q <= 1'b1;
        end else begin
            case (state_q)
                FADE_IN: begin
                    if (refresh) begin
                        if (div_q == DIV_LAST) begin
                            div_q   <= '0;
                            level_q <= level_q + 5'd1;
                            if (level_q == 5'd15) begin
                                state_q <= OPENING;
                            end
                        end else begin
                            div_q <= div_q + 16'd1;
                        end
                    end
                end
                OPENING: begin
                    if (i_key) begin
                        state_q <= FADE_OUT;
                        div_q   <= '0;
                    end
                end
                FADE_OUT: begin
                    if (refresh) begin
                        if (div_q == DIV_LAST) begin
                            div_q   <= '0;
                            level_q <= level_q - 5'd1;
                            if (level_q == 5'd1) begin
                                state_q   <= DONE;
                                opening_q <= 1'b0;
                            end
                        end else begin
                            div_q <= div_q + 16'd1;
                        end
                    end
                end
                DONE: begin
                    level_q   <= '0;
                    opening_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_splash_compositor.sv
// tb_splash_compositor: directed scoreboard bench for splash_compositor
module tb_splash_compositor;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [12:0] h_count = '0;
    logic signed [12:0] v_count = '0;
    logic [19:0]        sram_addr;
    logic               sram_req;
    logic [15:0]        sram_data = '0;
    logic               key = 1'b0;
    logic               restart = 1'b0;
    logic [9:0]         red, green, blue;
    logic               opening;
    logic [4:0]         fade_level;

    int tests = 0;
    int fails = 0;
    logic [29:0] sb [$];

    localparam logic [19:0] L2_BASE = 20'hB98C0;

    splash_compositor dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_h_count    (h_count),
        .i_v_count    (v_count),
        .o_sram_addr  (sram_addr),
        .o_sram_req   (sram_req),
        .i_sram_data  (sram_data),
        .i_key        (key),
        .i_restart    (restart),
        .o_red        (red),
        .o_green      (green),
        .o_blue       (blue),
        .o_opening    (opening),
        .o_fade_level (fade_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input logic [15:0] d = 16'h0, input logic k = 1'b0, input logic r = 1'b0);
        h_count   = 13'(h);
        v_count   = 13'(v);
        sram_data = d;
        key       = k;
        restart   = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic frame;
        drive(0, 0);
        tick();
        drive(1, 0);
        tick();
    endtask

    function automatic logic [29:0] model(input logic hit, input logic [15:0] d, input int lvl);
        int c [3];
        if (hit && d[0]) begin
            c[0] = int'(d[15:11]) * 33;
            c[1] = int'(d[10:6]) * 33;
            c[2] = int'(d[5:1]) * 33;
        end else begin
            c[0] = 'hF8 * 4;
            c[1] = 'hF8 * 4;
            c[2] = 'hF8 * 4;
        end
        return {10'((c[0] * lvl) / 16), 10'((c[1] * lvl) / 16), 10'((c[2] * lvl) / 16)};
    endfunction

    task automatic px(input string tag, input int h, input int v, input logic [15:0] d,
                      input logic [19:0] ea, input logic er, input int lvl);
        logic [29:0] e;
        drive(h, v, d);
        #1;
        chk({tag, "_addr"}, 32'(sram_addr), 32'(ea));
        chk({tag, "_req"}, 32'(sram_req), 32'(er));
        sb.push_back(model(er, d, lvl));
        tick();
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            assert ({red, green, blue} === e) else begin
                fails++;
                $error("FAIL %s_rgb: observed %h expected %h", tag, {red, green, blue}, e);
            end
        end
    endtask

    initial begin
        drive(5, 5);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_level", 32'(fade_level), 0);
        chk("rst_opening", 32'(opening), 1);
        chk("rst_rgb", 32'({red, green, blue}), 0);

        for (int f = 1; f <= 32; f++) begin
            frame();
            chk("fadein_lvl", 32'(fade_level), 32'(f / 2));
            if (f == 4) begin
                drive(1, 0, 16'h0, 1'b1);
                tick();
                drive(1, 0);
            end
        end
        chk("opening_after_fadein", 32'(opening), 1);
        frame();
        frame();
        chk("opening_hold_lvl", 32'(fade_level), 16);

        px("l0_red", 516, 227, 16'hF801, 20'h00000, 1'b1, 16);
        chk("l0_red_lit", 32'(red), 32'h3FF);
        px("l2_transp", 216, 27, 16'hF800, L2_BASE, 1'b1, 16);
        px("no_win", 100, 27, 16'h07C1, 20'h0, 1'b0, 16);
        px("l0_green", 517, 227, 16'h07C1, 20'h00001, 1'b1, 16);
        px("l1_blue", 911, 27, 16'h003F, 20'hC8320, 1'b1, 16);
        px("l0_transp_white", 518, 227, 16'hFFFE, 20'h00002, 1'b1, 16);

        drive(0, 0);
        tick();
        for (int v = 27; v < 627; v++) begin
            for (int h = 216; h < 316; h++) begin
                drive(h, v);
                if (v == 28 && h == 216) begin
                    #1;
                    chk("l2_line2", 32'(sram_addr), 32'(L2_BASE + 20'd100));
                end
                if (v == 626 && h == 315) begin
                    #1;
                    chk("l2_last", 32'(sram_addr), 32'(L2_BASE + 20'd59999));
                end
                tick();
            end
        end
        drive(0, 0);
        tick();
        px("l2_reload", 216, 27, 16'h0001, L2_BASE, 1'b1, 16);

        drive(1, 0, 16'h0, 1'b1);
        tick();
        drive(1, 0);
        chk("key_lvl", 32'(fade_level), 16);
        for (int f = 1; f <= 32; f++) begin
            frame();
            chk("fadeout_lvl", 32'(fade_level), 32'(16 - f / 2));
            chk("fadeout_open", 32'(opening), (f < 32) ? 1 : 0);
        end
        px("done_black", 516, 227, 16'hF801, 20'h00000, 1'b1, 0);
        drive(1, 0, 16'h0, 1'b1);
        tick();
        drive(1, 0);
        frame();
        frame();
        chk("done_key_lvl", 32'(fade_level), 0);
        chk("done_key_open", 32'(opening), 0);

        drive(1, 0, 16'h0, 1'b0, 1'b1);
        tick();
        drive(1, 0);
        chk("restart_lvl", 32'(fade_level), 0);
        chk("restart_open", 32'(opening), 1);
        for (int f = 1; f <= 32; f++) begin
            frame();
            chk("refade_lvl", 32'(fade_level), 32'(f / 2));
        end
        drive(1, 0, 16'h0, 1'b1);
        tick();
        drive(1, 0);
        for (int f = 1; f <= 14; f++) begin
            frame();
            chk("fadeout2_lvl", 32'(fade_level), 32'(16 - f / 2));
        end
        px("lvl9_red", 516, 227, 16'hF801, 20'h00000, 1'b1, 9);
        chk("lvl9_red_lit", 32'(red), 32'd575);
        drive(1, 0, 16'h0, 1'b1, 1'b1);
        tick();
        drive(1, 0);
        chk("kr_lvl", 32'(fade_level), 0);
        chk("kr_open", 32'(opening), 1);
        frame();
        frame();
        chk("kr_fadein_lvl", 32'(fade_level), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
